// File: rtl/cur_mb_fetch_if.sv
// Memory read bus and pixel stream between the current-frame fetcher (master)
// and its memory / ME engine (slave).
interface cur_mb_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rd_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [31:0]       pix_data;
    logic              pix_last;

    modport master (
        output mem_rd_en, mem_addr, pix_valid, pix_data, pix_last,
        input  mem_rd_data, pix_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, pix_valid, pix_data, pix_last,
        output mem_rd_data, pix_ready
    );
endinterface

// File: rtl/cur_mb_fetch.sv
// Current-frame macroblock fetcher: raster MB walk, 64 word reads per MB, 4-deep return FIFO.
// Define CUR_FRAME_WRAP_EN to restart at MB (0,0) after the last MB instead of going idle.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | issuing the 64 word reads of the current MB
// DRAIN     | all reads issued, streaming out until the last word handshakes
// WAIT_DONE | waiting for mb_done from the ME engine
module cur_mb_fetch #(
    parameter int              FRAME_W   = 256,
    parameter int              FRAME_H   = 128,
    parameter longint unsigned BASE_ADDR = 0,
    parameter int              ADDR_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    cur_mb_fetch_if.master        bus,
    output logic [7:0]            mb_x,
    output logic [7:0]            mb_y,
    input  logic                  mb_done,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int MB_COLS = FRAME_W / 16;
    localparam int MB_ROWS = FRAME_H / 16;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WAIT_DONE} state_t;

    state_t            state;
    logic              rd_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [5:0]        issue_idx;
    logic              rd_pending;
    logic [31:0]       fifo_mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        fifo_count;
    logic [5:0]        out_idx;
    logic              pix_valid;
    logic              pop;
    logic              can_issue;
    logic              last_col;
    logic              last_mb;
    logic [7:0]        nx_x;
    logic [7:0]        nx_y;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [7:0] bx, input logic [7:0] by,
                                                     input logic [5:0] k);
        logic [ADDR_W-1:0] line;
        line = ADDR_W'(by) * ADDR_W'(16) + ADDR_W'(k[5:2]);
        return ADDR_W'(BASE_ADDR) + line * ADDR_W'(FRAME_W) + ADDR_W'(bx) * ADDR_W'(16)
               + ADDR_W'({k[1:0], 2'b00});
    endfunction

    assign pix_valid = (fifo_count != 3'd0);
    assign pop       = pix_valid && bus.pix_ready;
    // Count the read on the bus now plus the one whose data lands this cycle.
    assign can_issue = (fifo_count + 3'(rd_en_q) + 3'(rd_pending)) < 3'd4;
    assign last_col  = (mb_x == 8'(MB_COLS - 1));
    assign last_mb   = last_col && (mb_y == 8'(MB_ROWS - 1));
    assign nx_x      = last_col ? 8'd0 : mb_x + 8'd1;
    assign nx_y      = last_col ? mb_y + 8'd1 : mb_y;

    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.pix_valid = pix_valid;
    assign bus.pix_data  = fifo_mem[rd_ptr];
    assign bus.pix_last  = pix_valid && (out_idx == 6'd63);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            issue_idx  <= '0;
            mb_x       <= '0;
            mb_y       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rd_en_q    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mb_x      <= '0;
                        mb_y      <= '0;
                        busy      <= 1'b1;
                        rd_en_q   <= 1'b1;
                        addr_q    <= word_addr(8'd0, 8'd0, 6'd0);
                        issue_idx <= 6'd1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (can_issue) begin
                        rd_en_q   <= 1'b1;
                        addr_q    <= word_addr(mb_x, mb_y, issue_idx);
                        issue_idx <= issue_idx + 6'd1;
                        if (issue_idx == 6'd63) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_idx == 6'd63) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (mb_done) begin
                        frame_done <= last_mb;
                        if (last_mb) begin
`ifdef CUR_FRAME_WRAP_EN
                            mb_x      <= '0;
                            mb_y      <= '0;
                            rd_en_q   <= 1'b1;
                            addr_q    <= word_addr(8'd0, 8'd0, 6'd0);
                            issue_idx <= 6'd1;
                            state     <= FETCH;
`else
                            busy  <= 1'b0;
                            state <= IDLE;
`endif
                        end else begin
                            mb_x      <= nx_x;
                            mb_y      <= nx_y;
                            rd_en_q   <= 1'b1;
                            addr_q    <= word_addr(nx_x, nx_y, 6'd0);
                            issue_idx <= 6'd1;
                            state     <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return FIFO; read data is captured the cycle after its strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pending <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_idx    <= '0;
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
        end else begin
            rd_pending <= rd_en_q;
            if (rd_pending) begin
                fifo_mem[wr_ptr] <= bus.mem_rd_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 2'd1;
                out_idx <= out_idx + 6'd1;
            end
            fifo_count <= fifo_count + 3'(rd_pending) - 3'(pop);
        end
    end
endmodule
